// File: rtl/sub_bytes_iter_if.sv
// Handshake bundle for the iterative SubBytes stage: an input block channel
// and an output block channel, each with valid/ready.
interface sub_bytes_iter_if #(
  parameter int BYTES = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [8*BYTES-1:0]   blocoIn;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*BYTES-1:0]   blocoOut;

  // Upstream/downstream side: supplies blocks and accepts results.
  modport master (
    output in_valid, blocoIn, out_ready,
    input  in_ready, out_valid, blocoOut
  );

  // Substitution engine side.
  modport slave (
    input  in_valid, blocoIn, out_ready,
    output in_ready, out_valid, blocoOut
  );
endinterface

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: captures a BYTES-byte block, substitutes LANES bytes
// per enabled cycle in place through LANES forward S-boxes, then holds the
// finished block on a registered output until the downstream takes it.
// Byte 0 of a block is the most-significant byte.
module sub_bytes_iter #(
  parameter int BYTES = 16,
  parameter int LANES = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  sub_bytes_iter_if.slave bus,
  output logic          busy
);

  localparam int N  = BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W  = 8 * BYTES;

  if (BYTES % LANES != 0) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must divide BYTES");
  end

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [W-1:0]        data_p0;
  logic [W-1:0]        data_upd;
  logic [W-1:0]        blocoout_p1;
  logic                vld_p1;
  logic [8*LANES-1:0]  lane_in;
  logic [8*LANES-1:0]  lane_out;
  logic                accept;
  logic                last;
  logic                drain;

  assign bus.in_ready  = reset & enable & (state == IDLE);
  assign bus.out_valid = vld_p1;
  assign bus.blocoOut  = blocoout_p1;
  assign busy          = (state == RUN);

  // Handshake qualifiers; a frozen block neither accepts nor drains.
  always_comb begin
    accept = bus.in_valid & bus.in_ready;
    last   = (cnt == CW'(N - 1));
    drain  = enable & vld_p1 & bus.out_ready;
  end

  // Lane operands: the current chunk in RUN, otherwise held at zero so the
  // S-box cones do not toggle while idle or frozen.
  always_comb begin
    lane_in = '0;
    if (state == RUN && enable) begin
      for (int l = 0; l < LANES; l++) begin
        lane_in[8*(LANES-1-l) +: 8] = data_p0[W-1-8*(int'(cnt)*LANES+l) -: 8];
      end
    end
  end

  // S-box lanes and in-place merge of the substituted chunk.
  always_comb begin
    lane_out = '0;
    data_upd = data_p0;
    for (int l = 0; l < LANES; l++) begin
      lane_out[8*(LANES-1-l) +: 8] = SBOX[lane_in[8*(LANES-1-l) +: 8]];
      data_upd[W-1-8*(int'(cnt)*LANES+l) -: 8] = lane_out[8*(LANES-1-l) +: 8];
    end
  end

  // Next-state: IDLE -> RUN on accept, RUN -> DONE after the last chunk,
  // DONE -> IDLE on the output handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (enable && last) state_nxt = DONE;
      DONE:    if (drain) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture / iterate / publish: block register, chunk counter, output stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_p0     <= '0;
      cnt         <= '0;
      blocoout_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_p0 <= bus.blocoIn;
            cnt     <= '0;
          end
        end
        RUN: begin
          data_p0 <= data_upd;
          if (last) begin
            cnt         <= '0;
            blocoout_p1 <= data_upd;
            vld_p1      <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) vld_p1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A presented block must not change while the downstream is stalling.
  a_out_stable: assert property (@(posedge clock) disable iff (!reset)
    (vld_p1 && !bus.out_ready) |=> $stable(blocoout_p1))
    else $error("sub_bytes_iter: blocoOut changed under backpressure");
`endif

endmodule
